pkt_filter: RTL and testbench

Ingress classifier sitting directly upstream of the parser. It takes the 256-bit AXI-Stream from the MAC/DMA side and inspects the first two beats of each packet. It then steers the packet to one of three destinations: the parser data input (VLAN-tagged data packets), the parser control input (reconfiguration packets identified by UDP destination port), or a drop sink (everything else).

---
 rtl/pkt_filter.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_pkt_filter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_filter.sv
// -----------------------------------------------------------------------------
// pkt_filter
//
// Ingress classifier placed directly upstream of the parser. It looks at the
// first two beats of every packet on the 256-bit AXI-Stream and steers the
// whole packet to one of three places:
//   - parser data input    (m_axis_*)      : VLAN-tagged packets that are not control
//   - parser control input (ctrl_m_axis_*) : VLAN/IPv4/UDP packets whose UDP
//                                            destination port equals CTRL_UDP_PORT
//   - drop sink                            : untagged packets and 1-beat runts
//
// The two head beats are buffered and replayed (EMIT0/EMIT1). The rest of the
// packet then flows through combinationally (FWD).
//
// Ports
//   axis_clk, areset          : clock and asynchronous active-high reset
//   s_axis_*                  : ingress stream (byte 0 of the frame = tdata[7:0])
//   m_axis_*                  : data stream to the parser (honours m_axis_tready)
//   ctrl_m_axis_*             : control stream to the parser (no ready; the
//                               consumer accepts every valid beat)
//   data_pkt_cnt, ctrl_pkt_cnt, drop_pkt_cnt (only with PKT_FILTER_STATS_EN):
//                               32-bit wrap-around classification counters
//
// Optional feature macro: PKT_FILTER_STATS_EN
// Only C_S_AXIS_DATA_WIDTH = 256 is supported (the field offsets are fixed).
// -----------------------------------------------------------------------------
module pkt_filter #(
    parameter int          C_S_AXIS_DATA_WIDTH  = 256,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter logic [15:0] CTRL_UDP_PORT        = 16'hF1F2
) (
    input  logic                                axis_clk,
    input  logic                                areset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic                                s_axis_tvalid,
    input  logic                                s_axis_tlast,
    output logic                                s_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    input  logic                                m_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]      ctrl_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]     ctrl_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    ctrl_m_axis_tkeep,
    output logic                                ctrl_m_axis_tvalid,
    output logic                                ctrl_m_axis_tlast
`ifdef PKT_FILTER_STATS_EN
    ,
    output logic [31:0]                         data_pkt_cnt,
    output logic [31:0]                         ctrl_pkt_cnt,
    output logic [31:0]                         drop_pkt_cnt
`endif
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_2ND  = 3'd1,
        ST_EMIT0     = 3'd2,
        ST_EMIT1     = 3'd3,
        ST_FWD       = 3'd4,
        ST_DROP_REST = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            is_ctrl_q, is_ctrl_d;

    logic [DW-1:0]   beat0_data_q, beat0_data_d;
    logic [UW-1:0]   beat0_user_q, beat0_user_d;
    logic [KW-1:0]   beat0_keep_q, beat0_keep_d;
    logic            beat0_last_q, beat0_last_d;

    logic [DW-1:0]   beat1_data_q, beat1_data_d;
    logic [UW-1:0]   beat1_user_q, beat1_user_d;
    logic [KW-1:0]   beat1_keep_q, beat1_keep_d;
    logic            beat1_last_q, beat1_last_d;

    // ------------------------------------------------------------------
    // Header fields. Network byte order: the lower frame byte offset is the
    // most significant byte of each 16-bit field.
    // Beat0 is already registered when beat1 arrives, so the decision is
    // made from the beat0 register plus the live beat1 bus.
    // ------------------------------------------------------------------
    logic [15:0] tpid_f;
    logic [15:0] etype_f;
    logic [7:0]  proto_f;
    logic [15:0] dport_f;
    logic        vlan_hit;
    logic        ctrl_hit;

    assign tpid_f   = {beat0_data_q[103:96],  beat0_data_q[111:104]};  // bytes 12-13
    assign etype_f  = {beat0_data_q[135:128], beat0_data_q[143:136]};  // bytes 16-17
    assign proto_f  = beat0_data_q[223:216];                           // byte 27
    assign dport_f  = {s_axis_tdata[71:64],   s_axis_tdata[79:72]};    // bytes 40-41

    assign vlan_hit = (tpid_f == 16'h8100);
    assign ctrl_hit = vlan_hit && (etype_f == 16'h0800) && (proto_f == 8'h11)
                      && (dport_f == CTRL_UDP_PORT);

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d            = state_q;
        is_ctrl_d          = is_ctrl_q;
        beat0_data_d       = beat0_data_q;
        beat0_user_d       = beat0_user_q;
        beat0_keep_d       = beat0_keep_q;
        beat0_last_d       = beat0_last_q;
        beat1_data_d       = beat1_data_q;
        beat1_user_d       = beat1_user_q;
        beat1_keep_d       = beat1_keep_q;
        beat1_last_d       = beat1_last_q;

        s_axis_tready      = 1'b0;
        m_axis_tdata       = '0;
        m_axis_tuser       = '0;
        m_axis_tkeep       = '0;
        m_axis_tvalid      = 1'b0;
        m_axis_tlast       = 1'b0;
        ctrl_m_axis_tdata  = '0;
        ctrl_m_axis_tuser  = '0;
        ctrl_m_axis_tkeep  = '0;
        ctrl_m_axis_tvalid = 1'b0;
        ctrl_m_axis_tlast  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    beat0_data_d = s_axis_tdata;
                    beat0_user_d = s_axis_tuser;
                    beat0_keep_d = s_axis_tkeep;
                    beat0_last_d = s_axis_tlast;
                    // A runt (tlast on beat0) is silently discarded.
                    state_d      = s_axis_tlast ? ST_IDLE : ST_WAIT_2ND;
                end
            end

            ST_WAIT_2ND: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    beat1_data_d = s_axis_tdata;
                    beat1_user_d = s_axis_tuser;
                    beat1_keep_d = s_axis_tkeep;
                    beat1_last_d = s_axis_tlast;
                    is_ctrl_d    = ctrl_hit;
                    if (!vlan_hit) begin
                        state_d = s_axis_tlast ? ST_IDLE : ST_DROP_REST;
                    end else begin
                        state_d = ST_EMIT0;
                    end
                end
            end

            ST_EMIT0: begin
                if (is_ctrl_q) begin
                    // Control consumer never stalls: one cycle per beat.
                    ctrl_m_axis_tdata  = beat0_data_q;
                    ctrl_m_axis_tuser  = beat0_user_q;
                    ctrl_m_axis_tkeep  = beat0_keep_q;
                    ctrl_m_axis_tlast  = beat0_last_q;
                    ctrl_m_axis_tvalid = 1'b1;
                    state_d            = ST_EMIT1;
                end else begin
                    m_axis_tdata  = beat0_data_q;
                    m_axis_tuser  = beat0_user_q;
                    m_axis_tkeep  = beat0_keep_q;
                    m_axis_tlast  = beat0_last_q;
                    m_axis_tvalid = 1'b1;
                    if (m_axis_tready) begin
                        state_d = ST_EMIT1;
                    end
                end
            end

            ST_EMIT1: begin
                if (is_ctrl_q) begin
                    ctrl_m_axis_tdata  = beat1_data_q;
                    ctrl_m_axis_tuser  = beat1_user_q;
                    ctrl_m_axis_tkeep  = beat1_keep_q;
                    ctrl_m_axis_tlast  = beat1_last_q;
                    ctrl_m_axis_tvalid = 1'b1;
                    state_d            = beat1_last_q ? ST_IDLE : ST_FWD;
                end else begin
                    m_axis_tdata  = beat1_data_q;
                    m_axis_tuser  = beat1_user_q;
                    m_axis_tkeep  = beat1_keep_q;
                    m_axis_tlast  = beat1_last_q;
                    m_axis_tvalid = 1'b1;
                    if (m_axis_tready) begin
                        state_d = beat1_last_q ? ST_IDLE : ST_FWD;
                    end
                end
            end

            ST_FWD: begin
                if (is_ctrl_q) begin
                    s_axis_tready      = 1'b1;
                    ctrl_m_axis_tdata  = s_axis_tdata;
                    ctrl_m_axis_tuser  = s_axis_tuser;
                    ctrl_m_axis_tkeep  = s_axis_tkeep;
                    ctrl_m_axis_tlast  = s_axis_tlast;
                    ctrl_m_axis_tvalid = s_axis_tvalid;
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    // Zero-latency pass-through; backpressure goes straight upstream.
                    s_axis_tready = m_axis_tready;
                    m_axis_tdata  = s_axis_tdata;
                    m_axis_tuser  = s_axis_tuser;
                    m_axis_tkeep  = s_axis_tkeep;
                    m_axis_tlast  = s_axis_tlast;
                    m_axis_tvalid = s_axis_tvalid;
                    if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_DROP_REST: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are forced quiet while reset is held, including the
        // combinational FWD path which would otherwise follow s_axis.
        if (areset) begin
            s_axis_tready      = 1'b0;
            m_axis_tdata       = '0;
            m_axis_tuser       = '0;
            m_axis_tkeep       = '0;
            m_axis_tvalid      = 1'b0;
            m_axis_tlast       = 1'b0;
            ctrl_m_axis_tdata  = '0;
            ctrl_m_axis_tuser  = '0;
            ctrl_m_axis_tkeep  = '0;
            ctrl_m_axis_tvalid = 1'b0;
            ctrl_m_axis_tlast  = 1'b0;
        end
    end

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            is_ctrl_q    <= 1'b0;
            beat0_data_q <= '0;
            beat0_user_q <= '0;
            beat0_keep_q <= '0;
            beat0_last_q <= 1'b0;
            beat1_data_q <= '0;
            beat1_user_q <= '0;
            beat1_keep_q <= '0;
            beat1_last_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_ctrl_q    <= is_ctrl_d;
            beat0_data_q <= beat0_data_d;
            beat0_user_q <= beat0_user_d;
            beat0_keep_q <= beat0_keep_d;
            beat0_last_q <= beat0_last_d;
            beat1_data_q <= beat1_data_d;
            beat1_user_q <= beat1_user_d;
            beat1_keep_q <= beat1_keep_d;
            beat1_last_q <= beat1_last_d;
        end
    end

`ifdef PKT_FILTER_STATS_EN
    // ------------------------------------------------------------------
    // Classification counters. IDLE and WAIT_2ND always accept, so a valid
    // beat in those states is a handshake.
    // ------------------------------------------------------------------
    logic        data_inc;
    logic        ctrl_inc;
    logic        drop_inc;
    logic [31:0] data_pkt_cnt_q, data_pkt_cnt_d;
    logic [31:0] ctrl_pkt_cnt_q, ctrl_pkt_cnt_d;
    logic [31:0] drop_pkt_cnt_q, drop_pkt_cnt_d;

    assign data_inc = (state_q == ST_WAIT_2ND) && s_axis_tvalid && vlan_hit && !ctrl_hit;
    assign ctrl_inc = (state_q == ST_WAIT_2ND) && s_axis_tvalid && ctrl_hit;
    assign drop_inc = ((state_q == ST_IDLE) && s_axis_tvalid && s_axis_tlast)
                   || ((state_q == ST_WAIT_2ND) && s_axis_tvalid && !vlan_hit);

    always_comb begin
        // Plain 32-bit addition wraps from 32'hFFFFFFFF to 0.
        data_pkt_cnt_d = data_pkt_cnt_q + {31'd0, data_inc};
        ctrl_pkt_cnt_d = ctrl_pkt_cnt_q + {31'd0, ctrl_inc};
        drop_pkt_cnt_d = drop_pkt_cnt_q + {31'd0, drop_inc};
    end

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            data_pkt_cnt_q <= '0;
            ctrl_pkt_cnt_q <= '0;
            drop_pkt_cnt_q <= '0;
        end else begin
            data_pkt_cnt_q <= data_pkt_cnt_d;
            ctrl_pkt_cnt_q <= ctrl_pkt_cnt_d;
            drop_pkt_cnt_q <= drop_pkt_cnt_d;
        end
    end

    assign data_pkt_cnt = data_pkt_cnt_q;
    assign ctrl_pkt_cnt = ctrl_pkt_cnt_q;
    assign drop_pkt_cnt = drop_pkt_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_filter.sv
// -----------------------------------------------------------------------------
// tb_pkt_filter
//
// Directed bench for pkt_filter. Inputs are driven 1 ns after the rising edge;
// a monitor samples the DUT on the falling edge and records every beat that
// transfers on the data and control outputs. Each test builds a packet with
// known header fields, sends it and compares the recorded output beats with
// the packet that was sent.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pkt_filter;

    localparam logic [127:0] UMASK = {4{32'h5A5AC3C3}};

    logic         axis_clk = 1'b0;
    logic         areset;
    logic [255:0] s_axis_tdata;
    logic [127:0] s_axis_tuser;
    logic [31:0]  s_axis_tkeep;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [127:0] m_axis_tuser;
    logic [31:0]  m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;
    logic [255:0] ctrl_m_axis_tdata;
    logic [127:0] ctrl_m_axis_tuser;
    logic [31:0]  ctrl_m_axis_tkeep;
    logic         ctrl_m_axis_tvalid;
    logic         ctrl_m_axis_tlast;
`ifdef PKT_FILTER_STATS_EN
    logic [31:0]  data_pkt_cnt;
    logic [31:0]  ctrl_pkt_cnt;
    logic [31:0]  drop_pkt_cnt;
`endif

    logic toggle_en = 1'b0;
    logic tog = 1'b1;
    assign m_axis_tready = toggle_en ? tog : 1'b1;

    pkt_filter dut (
        .axis_clk           (axis_clk),
        .areset             (areset),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tuser       (s_axis_tuser),
        .s_axis_tkeep       (s_axis_tkeep),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tready      (s_axis_tready),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tuser       (m_axis_tuser),
        .m_axis_tkeep       (m_axis_tkeep),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tlast       (m_axis_tlast),
        .m_axis_tready      (m_axis_tready),
        .ctrl_m_axis_tdata  (ctrl_m_axis_tdata),
        .ctrl_m_axis_tuser  (ctrl_m_axis_tuser),
        .ctrl_m_axis_tkeep  (ctrl_m_axis_tkeep),
        .ctrl_m_axis_tvalid (ctrl_m_axis_tvalid),
        .ctrl_m_axis_tlast  (ctrl_m_axis_tlast)
`ifdef PKT_FILTER_STATS_EN
        ,
        .data_pkt_cnt       (data_pkt_cnt),
        .ctrl_pkt_cnt       (ctrl_pkt_cnt),
        .drop_pkt_cnt       (drop_pkt_cnt)
`endif
    );

    always #5 axis_clk = ~axis_clk;

    // m_axis_tready pattern 1-0-1-0 for the stall test
    always @(posedge axis_clk) begin
        #1;
        tog = ~tog;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Output monitor
    // ------------------------------------------------------------------
    typedef struct {
        logic [255:0] d;
        logic [127:0] u;
        logic [31:0]  k;
        logic         l;
        int           cyc;
    } beat_t;

    beat_t        m_q[$];
    beat_t        c_q[$];
    int           cyc = 0;
    int           tready_low = 0;
    logic         prev_stall = 1'b0;
    logic [255:0] prev_data = '0;

    always @(negedge axis_clk) begin
        cyc++;
        if (!areset && !s_axis_tready) tready_low++;
        if (m_axis_tvalid && m_axis_tready)
            m_q.push_back('{m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast, cyc});
        if (ctrl_m_axis_tvalid)
            c_q.push_back('{ctrl_m_axis_tdata, ctrl_m_axis_tuser, ctrl_m_axis_tkeep,
                            ctrl_m_axis_tlast, cyc});
        if (prev_stall && !areset) begin
            chk("stall_valid_hold", 256'(m_axis_tvalid), 256'd1);
            chk("stall_data_hold", m_axis_tdata, prev_data);
        end
        prev_stall = m_axis_tvalid && !m_axis_tready && !areset;
        prev_data  = m_axis_tdata;
    end

    // ------------------------------------------------------------------
    // Packet construction
    // ------------------------------------------------------------------
    logic [255:0] pkt[8];

    function automatic logic [255:0] filler(input logic [7:0] seed, input int idx);
        return {8{seed, 8'hA5, 8'h3C, 8'(idx)}};
    endfunction

    task automatic build(input int n, input logic [15:0] tpid, input logic [15:0] et,
                         input logic [7:0] pr, input logic [15:0] port, input logic [7:0] seed);
        logic [255:0] d;
        d = filler(seed, 0);
        d[103:96]  = tpid[15:8];
        d[111:104] = tpid[7:0];
        d[119:112] = 8'h00;             // TCI: VID 5
        d[127:120] = 8'h05;
        d[135:128] = et[15:8];
        d[143:136] = et[7:0];
        d[223:216] = pr;
        pkt[0] = d;
        d = filler(seed, 1);
        d[71:64] = port[15:8];
        d[79:72] = port[7:0];
        pkt[1] = d;
        for (int i = 2; i < n; i++) pkt[i] = filler(seed, i);
    endtask

    function automatic logic [31:0] keep_for(input int i, input int n);
        return (i == n - 1) ? 32'h0000FFFF : 32'hFFFFFFFF;
    endfunction

    // Entered and left 1 ns after a rising edge.
    task automatic send_beat(input logic [255:0] d, input logic last, input logic [31:0] keep);
        int waited;
        waited = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = d[127:0] ^ UMASK;
        s_axis_tkeep  = keep;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge axis_clk);
            if (s_axis_tready) break;
            waited++;
            if (waited > 40) begin
                chk("s_tready_timeout", 256'(s_axis_tready), 256'd1);
                break;
            end
        end
        @(posedge axis_clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input int n);
        for (int i = 0; i < n; i++) send_beat(pkt[i], i == n - 1, keep_for(i, n));
        repeat (4) @(posedge axis_clk);
        #1;
    endtask

    task automatic verify(input string tag, input int n, input logic to_ctrl,
                          input int mb, input int cb);
        int    got_m;
        int    got_c;
        beat_t b;
        got_m = m_q.size() - mb;
        got_c = c_q.size() - cb;
        chk({tag, "_m_beats"}, 256'(got_m), 256'(to_ctrl ? 0 : n));
        chk({tag, "_c_beats"}, 256'(got_c), 256'(to_ctrl ? n : 0));
        for (int i = 0; i < n; i++) begin
            if (to_ctrl ? (i < got_c) : (i < got_m)) begin
                b = to_ctrl ? c_q[cb + i] : m_q[mb + i];
                chk($sformatf("%s_data%0d", tag, i), b.d, pkt[i]);
                chk($sformatf("%s_last%0d", tag, i), 256'(b.l), 256'(i == n - 1));
                chk($sformatf("%s_user%0d", tag, i), 256'(b.u), 256'(pkt[i][127:0] ^ UMASK));
                chk($sformatf("%s_keep%0d", tag, i), 256'(b.k), 256'(keep_for(i, n)));
                if (to_ctrl && i > 0)
                    chk($sformatf("%s_consec%0d", tag, i), 256'(b.cyc), 256'(c_q[cb].cyc + i));
            end
        end
        $display("pkt %s: beats=%0d dest=%s m_out=%0d c_out=%0d", tag, n,
                 to_ctrl ? "ctrl" : (n == 0 ? "drop" : "data"), got_m, got_c);
    endtask

    int mb, cb, tb;

    initial begin
        areset        = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;

        // Reset state
        repeat (2) @(posedge axis_clk);
        #1;
        chk("rst_s_tready", 256'(s_axis_tready), 256'd0);
        chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'd0);
        chk("rst_c_tvalid", 256'(ctrl_m_axis_tvalid), 256'd0);
        areset = 1'b0;
        @(negedge axis_clk);
        chk("post_rst_s_tready", 256'(s_axis_tready), 256'd1);
        @(posedge axis_clk);
        #1;

        // 3-beat VLAN/TCP data packet
        build(3, 16'h8100, 16'h0800, 8'h06, 16'h0050, 8'h11);
        mb = m_q.size(); cb = c_q.size(); tb = tready_low;
        send_pkt(3);
        verify("vlan_tcp", 3, 1'b0, mb, cb);
        chk("vlan_tcp_tready_low", 256'(tready_low - tb), 256'd2);

        // 4-beat control packet
        build(4, 16'h8100, 16'h0800, 8'h11, 16'hF1F2, 8'h22);
        mb = m_q.size(); cb = c_q.size(); tb = tready_low;
        send_pkt(4);
        verify("ctrl", 4, 1'b1, mb, cb);
        chk("ctrl_tready_low", 256'(tready_low - tb), 256'd2);

        // Same packet, other UDP port -> data
        build(4, 16'h8100, 16'h0800, 8'h11, 16'h1234, 8'h33);
        mb = m_q.size(); cb = c_q.size();
        send_pkt(4);
        verify("udp_1234", 4, 1'b0, mb, cb);

        // Untagged 2-beat packet -> dropped
        build(2, 16'h0800, 16'h4500, 8'h11, 16'hF1F2, 8'h44);
        mb = m_q.size(); cb = c_q.size();
        send_pkt(2);
        verify("untagged", 0, 1'b0, mb, cb);
`ifdef PKT_FILTER_STATS_EN
        chk("stat_data", 256'(data_pkt_cnt), 256'd2);
        chk("stat_ctrl", 256'(ctrl_pkt_cnt), 256'd1);
        chk("stat_drop", 256'(drop_pkt_cnt), 256'd1);
`endif

        // 1-beat tagged runt -> dropped, ready never drops
        build(1, 16'h8100, 16'h0800, 8'h11, 16'hF1F2, 8'h55);
        mb = m_q.size(); cb = c_q.size(); tb = tready_low;
        send_pkt(1);
        verify("runt", 0, 1'b0, mb, cb);
        chk("runt_tready_low", 256'(tready_low - tb), 256'd0);
        build(3, 16'h8100, 16'h0800, 8'h06, 16'h0050, 8'h66);
        mb = m_q.size(); cb = c_q.size();
        send_pkt(3);
        verify("after_runt", 3, 1'b0, mb, cb);

        // Data packet with toggling m_axis_tready
        toggle_en = 1'b1;
        build(5, 16'h8100, 16'h86DD, 8'h06, 16'h0050, 8'h77);
        mb = m_q.size(); cb = c_q.size();
        send_pkt(5);
        verify("stall", 5, 1'b0, mb, cb);
        toggle_en = 1'b0;

        // Reset while in FWD
        build(5, 16'h8100, 16'h0800, 8'h06, 16'h0050, 8'h88);
        send_beat(pkt[0], 1'b0, 32'hFFFFFFFF);
        send_beat(pkt[1], 1'b0, 32'hFFFFFFFF);
        send_beat(pkt[2], 1'b0, 32'hFFFFFFFF);
        s_axis_tdata  = pkt[3];
        s_axis_tvalid = 1'b1;
        #1;
        chk("fwd_pre_rst_m_tvalid", 256'(m_axis_tvalid), 256'd1);
        areset = 1'b1;
        #1;
        chk("fwd_rst_m_tvalid", 256'(m_axis_tvalid), 256'd0);
        chk("fwd_rst_c_tvalid", 256'(ctrl_m_axis_tvalid), 256'd0);
        chk("fwd_rst_s_tready", 256'(s_axis_tready), 256'd0);
        chk("fwd_rst_m_tdata", m_axis_tdata, 256'd0);
        s_axis_tvalid = 1'b0;
        @(posedge axis_clk);
        #1;
        areset = 1'b0;
        build(3, 16'h8100, 16'h0800, 8'h06, 16'h0050, 8'h99);
        mb = m_q.size(); cb = c_q.size();
        send_pkt(3);
        verify("after_rst", 3, 1'b0, mb, cb);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        chk("global_timeout", 256'(cyc), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
